// File: rtl/mips_pkg.sv
// Shared decode types and opcode constants for the MIPS ID/EX slice.
package mips_pkg;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic       jump;
    logic [2:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_ADDI  = 3'b011;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode: control bundle, which sources are read,
// and the destination register.
module id_decoder
  import mips_pkg::*;
#(
  parameter int RADDR_W = 5
) (
  input  logic [5:0]         opcode,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  output ctrl_t              ctrl,
  output logic               use_rs,
  output logic               use_rt,
  output logic [RADDR_W-1:0] wreg
);

  // Unlisted opcodes fall through to an all-zero control word (NOP).
  always_comb begin
    ctrl   = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    wreg   = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        ctrl.aluop    = ALU_RTYPE;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
        wreg          = rd;
      end
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        use_rs        = 1'b1;
        wreg          = rt;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        use_rs        = 1'b1;
        use_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_SUB;
        use_rs      = 1'b1;
        use_rt      = 1'b1;
      end
      OP_ADDI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADDI;
        use_rs        = 1'b1;
        wreg          = rt;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage with hazard detection, operand selection and the ID/EX register.
// Define ID_FORWARD_EN to forward from MEM/WB; otherwise stall on RAW hazards.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  input  logic [31:0]        if_instr,
  input  logic [XLEN-1:0]    if_pc4,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               mem_wen,
  input  logic [RADDR_W-1:0] mem_wreg,
  input  logic [XLEN-1:0]    mem_wdata,
  input  logic               wb_wen,
  input  logic [RADDR_W-1:0] wb_wreg,
  input  logic [XLEN-1:0]    wb_wdata,
  input  logic               ex_hold,
  input  logic               ex_flush,
  output logic               id_stall,
  output logic               ex_valid,
  output ctrl_t              ex_ctrl,
  output logic [XLEN-1:0]    ex_rs_val,
  output logic [XLEN-1:0]    ex_rt_val,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RADDR_W-1:0] ex_rs,
  output logic [RADDR_W-1:0] ex_rt,
  output logic [RADDR_W-1:0] ex_wreg,
  output logic [XLEN-1:0]    ex_pc4
);

  logic [RADDR_W-1:0] rs, rt, rd, wreg;
  logic [XLEN-1:0]    imm, rs_val, rt_val;
  ctrl_t              ctrl;
  logic               use_rs, use_rt, ex_match, hazard;

  assign rs        = if_instr[21 +: RADDR_W];
  assign rt        = if_instr[16 +: RADDR_W];
  assign rd        = if_instr[11 +: RADDR_W];
  assign imm       = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  id_decoder #(.RADDR_W(RADDR_W)) u_decoder (
    .opcode (if_instr[31:26]),
    .rt     (rt),
    .rd     (rd),
    .ctrl   (ctrl),
    .use_rs (use_rs),
    .use_rt (use_rt),
    .wreg   (wreg)
  );

  assign ex_match = ex_valid && (ex_wreg != '0) &&
                    ((use_rs && ex_wreg == rs) || (use_rt && ex_wreg == rt));

`ifdef ID_FORWARD_EN
  // Only a load in EX can't be bypassed; everything else comes from MEM/WB.
  assign hazard = if_valid && ex_match && ex_ctrl.memread;

  always_comb begin
    rs_val = rf_rdata1;
    if (rs != '0 && mem_wen && mem_wreg == rs)     rs_val = mem_wdata;
    else if (rs != '0 && wb_wen && wb_wreg == rs)  rs_val = wb_wdata;
    rt_val = rf_rdata2;
    if (rt != '0 && mem_wen && mem_wreg == rt)     rt_val = mem_wdata;
    else if (rt != '0 && wb_wen && wb_wreg == rt)  rt_val = wb_wdata;
  end
`else
  logic mem_match;
  logic unused_fwd;

  // Without bypassing, wait until the producer has left MEM; WB writes the RF in time.
  assign mem_match  = mem_wen && (mem_wreg != '0) &&
                      ((use_rs && mem_wreg == rs) || (use_rt && mem_wreg == rt));
  assign hazard     = if_valid && ((ex_match && ex_ctrl.regwrite) || mem_match);
  assign rs_val     = rf_rdata1;
  assign rt_val     = rf_rdata2;
  assign unused_fwd = ^{mem_wdata, wb_wen, wb_wreg, wb_wdata};
`endif

  assign id_stall = !rst && !ex_flush && (ex_hold || hazard);

  // Flush beats hold, hold beats hazard; a stall or empty slot enters EX as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_wreg   <= '0;
      ex_pc4    <= '0;
    end else if (ex_flush || (!ex_hold && (hazard || !if_valid))) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_wreg   <= '0;
      ex_pc4    <= '0;
    end else if (!ex_hold) begin
      ex_valid  <= 1'b1;
      ex_ctrl   <= ctrl;
      ex_rs_val <= rs_val;
      ex_rt_val <= rt_val;
      ex_imm    <= imm;
      ex_rs     <= rs;
      ex_rt     <= rt;
      ex_wreg   <= wreg;
      ex_pc4    <= if_pc4;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage plus hand-written stall, flush,
// hold and reset sequences. Expectations track the ID_FORWARD_EN setting.
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam logic [10:0] C_R    = 11'b10000100010;
  localparam logic [10:0] C_LW   = 11'b11011000000;
  localparam logic [10:0] C_SW   = 11'b00101000000;
  localparam logic [10:0] C_BEQ  = 11'b00000010001;
  localparam logic [10:0] C_ADDI = 11'b10001000011;
  localparam logic [10:0] C_J    = 11'b00000001000;
  localparam logic [10:0] C_NOP  = 11'b00000000000;

  logic        clk, rst, if_valid, mem_wen, wb_wen, ex_hold, ex_flush, id_stall, ex_valid;
  logic [31:0] if_instr, if_pc4, rf_rdata1, rf_rdata2, mem_wdata, wb_wdata;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc4;
  logic [4:0]  rf_raddr1, rf_raddr2, mem_wreg, wb_wreg, ex_rs, ex_rt, ex_wreg;
  ctrl_t       ex_ctrl;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_wen(mem_wen), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .wb_wen(wb_wen), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .ex_hold(ex_hold), .ex_flush(ex_flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_pc4(ex_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [31:0] rd1, rd2;
    logic        mwen;
    logic [4:0]  mwreg;
    logic [31:0] mwdata;
    logic        wwen;
    logic [4:0]  wwreg;
    logic [31:0] wwdata;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic [10:0] e_ctrl;
    logic [31:0] e_rs, e_rt, e_imm;
    logic [4:0]  e_wreg;
  } vec_t;

  vec_t tv[13];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic valid,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic flush, input logic hold);
    if_instr  = instr;
    if_valid  = valid;
    if_pc4    = 32'h2000;
    rf_rdata1 = rd1;
    rf_rdata2 = rd2;
    mem_wen   = 1'b0; mem_wreg = 5'd0; mem_wdata = 32'h0;
    wb_wen    = 1'b0; wb_wreg  = 5'd0; wb_wdata  = 32'h0;
    ex_flush  = flush;
    ex_hold   = hold;
  endtask

  // Check the combinational stall, then advance one edge and settle.
  task automatic stepCheck(input string name, input logic exp_stall);
    #1;
    checkOutput({name, ".id_stall"}, {31'd0, id_stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
  endtask

  task automatic checkZero(input string name);
    checkOutput({name, ".ex_valid"},  {31'd0, ex_valid}, 32'd0);
    checkOutput({name, ".ex_ctrl"},   32'(ex_ctrl), 32'd0);
    checkOutput({name, ".ex_rs_val"}, ex_rs_val, 32'd0);
    checkOutput({name, ".ex_rt_val"}, ex_rt_val, 32'd0);
    checkOutput({name, ".ex_imm"},    ex_imm, 32'd0);
    checkOutput({name, ".ex_regs"},   {17'd0, ex_rs, ex_rt, ex_wreg}, 32'd0);
    checkOutput({name, ".ex_pc4"},    ex_pc4, 32'd0);
    checkOutput({name, ".id_stall"},  {31'd0, id_stall}, 32'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tv[0]  = '{enc_r(1, 2, 3), 1, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_R, 32'd5, 32'd7, 32'h1820, 5'd3};
    tv[1]  = '{enc_i(6'd35, 6, 4, 16'hFFFC), 1, 32'h100, 32'h55, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_LW, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd4};
    tv[2]  = '{enc_i(6'd43, 8, 7, 16'h0008), 1, 32'h200, 32'h77, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_SW, 32'h200, 32'h77, 32'h8, 5'd0};
    tv[3]  = '{enc_i(6'd4, 9, 10, 16'h8000), 1, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_BEQ, 32'd1, 32'd2, 32'hFFFF8000, 5'd0};
    tv[4]  = '{enc_i(6'd8, 12, 11, 16'h7FFF), 1, 32'd3, 32'd9, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_ADDI, 32'd3, 32'd9, 32'h7FFF, 5'd11};
    tv[5]  = '{{6'd2, 26'h0123456}, 1, 32'hA, 32'hB, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_J, 32'hA, 32'hB, 32'h3456, 5'd0};
    tv[6]  = '{enc_i(6'd63, 1, 2, 16'h0010), 1, 32'd1, 32'd2, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_NOP, 32'd1, 32'd2, 32'h10, 5'd0};
    tv[7]  = '{enc_r(1, 2, 3), 0, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0,
               0, 0, C_NOP, 0, 0, 0, 5'd0};
    tv[8]  = '{enc_r(1, 2, 3), 1, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0, 1,
               0, 0, C_NOP, 0, 0, 0, 5'd0};
`ifdef ID_FORWARD_EN
    tv[9]  = '{enc_i(6'd8, 1, 13, 16'h0001), 1, 32'h11, 32'h0, 1, 1, 32'hAA, 1, 1, 32'hBB, 0,
               0, 1, C_ADDI, 32'hAA, 32'h0, 32'h1, 5'd13};
    tv[10] = '{enc_i(6'd8, 2, 14, 16'h0005), 1, 32'h22, 32'h3, 0, 0, 0, 1, 2, 32'hCC, 0,
               0, 1, C_ADDI, 32'hCC, 32'h3, 32'h5, 5'd14};
    tv[12] = '{enc_r(15, 0, 16), 1, 32'd5, 32'd6, 0, 0, 0, 0, 0, 0, 0,
               0, 1, C_R, 32'd5, 32'd6, 32'hFFFF8020, 5'd16};
`else
    tv[9]  = '{enc_i(6'd8, 1, 13, 16'h0001), 1, 32'h11, 32'h0, 1, 1, 32'hAA, 1, 1, 32'hBB, 0,
               1, 0, C_NOP, 0, 0, 0, 5'd0};
    tv[10] = '{enc_i(6'd8, 2, 14, 16'h0005), 1, 32'h22, 32'h3, 0, 0, 0, 1, 2, 32'hCC, 0,
               0, 1, C_ADDI, 32'h22, 32'h3, 32'h5, 5'd14};
    tv[12] = '{enc_r(15, 0, 16), 1, 32'd5, 32'd6, 0, 0, 0, 0, 0, 0, 0,
               1, 0, C_NOP, 0, 0, 0, 5'd0};
`endif
    tv[11] = '{enc_r(0, 0, 15), 1, 32'd0, 32'd0, 1, 0, 32'hDD, 1, 0, 32'hEE, 0,
               0, 1, C_R, 32'd0, 32'd0, 32'h7820, 5'd15};

    ex_hold = 1'b0;
    ex_flush = 1'b0;
    doReset();
    checkZero("reset");

    for (int i = 0; i < 13; i++) begin
      string tag;
      logic [31:0] pc;
      tag = $sformatf("vec%0d", i);
      pc  = 32'h1000 + 32'(i) * 4;
      if_instr = tv[i].instr; if_valid = tv[i].valid; if_pc4 = pc;
      rf_rdata1 = tv[i].rd1; rf_rdata2 = tv[i].rd2;
      mem_wen = tv[i].mwen; mem_wreg = tv[i].mwreg; mem_wdata = tv[i].mwdata;
      wb_wen = tv[i].wwen; wb_wreg = tv[i].wwreg; wb_wdata = tv[i].wwdata;
      ex_flush = tv[i].flush; ex_hold = 1'b0;
      #1;
      checkOutput({tag, ".rf_raddr"}, {22'd0, rf_raddr1, rf_raddr2},
                  {22'd0, tv[i].instr[25:21], tv[i].instr[20:16]});
      stepCheck(tag, tv[i].e_stall);
      checkOutput({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, tv[i].e_valid});
      checkOutput({tag, ".ex_ctrl"}, 32'(ex_ctrl), {21'd0, tv[i].e_ctrl});
      if (tv[i].e_valid) begin
        checkOutput({tag, ".ex_rs_val"}, ex_rs_val, tv[i].e_rs);
        checkOutput({tag, ".ex_rt_val"}, ex_rt_val, tv[i].e_rt);
        checkOutput({tag, ".ex_imm"}, ex_imm, tv[i].e_imm);
        checkOutput({tag, ".ex_wreg"}, {27'd0, ex_wreg}, {27'd0, tv[i].e_wreg});
        checkOutput({tag, ".ex_rs_rt"}, {22'd0, ex_rs, ex_rt},
                    {22'd0, tv[i].instr[25:21], tv[i].instr[20:16]});
        checkOutput({tag, ".ex_pc4"}, ex_pc4, pc);
      end
    end

    // Load-use: one stall, one bubble, then the consumer issues.
    doReset();
    applyStimulus(enc_i(6'd35, 1, 4, 16'h0), 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    stepCheck("lu.lw", 1'b0);
    checkOutput("lu.lw.ex_ctrl", 32'(ex_ctrl), {21'd0, C_LW});
    applyStimulus(enc_r(4, 4, 5), 1'b1, 32'h9, 32'h9, 1'b0, 1'b0);
    stepCheck("lu.stall", 1'b1);
    checkOutput("lu.bubble.ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("lu.bubble.ex_ctrl", 32'(ex_ctrl), 32'd0);
    stepCheck("lu.reissue", 1'b0);
    checkOutput("lu.add.ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("lu.add.ex_ctrl", 32'(ex_ctrl), {21'd0, C_R});
    checkOutput("lu.add.ex_wreg", {27'd0, ex_wreg}, 32'd5);
    checkOutput("lu.add.ex_rs_val", ex_rs_val, 32'h9);

    // Load-use hazard coinciding with a flush.
    applyStimulus(enc_i(6'd35, 1, 4, 16'h0), 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    stepCheck("fl.lw", 1'b0);
    applyStimulus(enc_r(4, 4, 5), 1'b1, 32'h9, 32'h9, 1'b1, 1'b0);
    stepCheck("fl.flush", 1'b0);
    checkOutput("fl.bubble.ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("fl.bubble.ex_ctrl", 32'(ex_ctrl), 32'd0);
    applyStimulus(enc_r(4, 4, 5), 1'b1, 32'h9, 32'h9, 1'b0, 1'b0);
    stepCheck("fl.after", 1'b0);
    checkOutput("fl.add.ex_valid", {31'd0, ex_valid}, 32'd1);

    // Hold for three cycles keeps the add in EX.
    applyStimulus(enc_i(6'd8, 1, 6, 16'h0007), 1'b1, 32'h31, 32'h0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      string tag;
      tag = $sformatf("hold%0d", c);
      stepCheck(tag, 1'b1);
      checkOutput({tag, ".ex_valid"}, {31'd0, ex_valid}, 32'd1);
      checkOutput({tag, ".ex_ctrl"}, 32'(ex_ctrl), {21'd0, C_R});
      checkOutput({tag, ".ex_wreg"}, {27'd0, ex_wreg}, 32'd5);
      checkOutput({tag, ".ex_rs_val"}, ex_rs_val, 32'h9);
    end
    ex_hold = 1'b0;
    stepCheck("hold.release", 1'b0);
    checkOutput("hold.addi.ex_ctrl", 32'(ex_ctrl), {21'd0, C_ADDI});
    checkOutput("hold.addi.ex_wreg", {27'd0, ex_wreg}, 32'd6);
    checkOutput("hold.addi.ex_rs_val", ex_rs_val, 32'h31);
    checkOutput("hold.addi.ex_imm", ex_imm, 32'h7);

    // Asynchronous reset in mid-cycle, then resume.
    applyStimulus(enc_r(6, 6, 7), 1'b1, 32'h1, 32'h1, 1'b0, 1'b0);
    #1;
`ifdef ID_FORWARD_EN
    checkOutput("rst.pre.id_stall", {31'd0, id_stall}, 32'd0);
`else
    checkOutput("rst.pre.id_stall", {31'd0, id_stall}, 32'd1);
`endif
    #1 rst = 1'b1;
    #1;
    checkZero("rst.mid");
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(enc_r(1, 2, 3), 1'b1, 32'd5, 32'd7, 1'b0, 1'b0);
    stepCheck("rst.resume", 1'b0);
    checkOutput("rst.resume.ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("rst.resume.ex_rs_val", ex_rs_val, 32'd5);
    checkOutput("rst.resume.ex_rt_val", ex_rt_val, 32'd7);
    checkOutput("rst.resume.ex_wreg", {27'd0, ex_wreg}, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width.
REQ-002 SHALL have parameter RADDR_W, 5, register-address width.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports if_valid/if_instr/if_pc4  input  1/32/32  instruction word and PC+4 from IF/ID.
REQ-006 SHALL have ports rf_raddr1/rf_raddr2  output  5  combinational rs/rt field of if_instr, to the register file.
REQ-007 SHALL have ports rf_rdata1/rf_rdata2  input  32  register-file read data.
REQ-008 SHALL have ports mem_wen/mem_wreg/mem_wdata and wb_wen/wb_wreg/wb_wdata  input  1/5/32  forwarding sources.
REQ-009 SHALL have ports ex_hold  input  1  downstream cannot accept; ex_flush  input  1  kill instruction in ID.
REQ-010 SHALL have port id_stall  output  1  hold PC and IF/ID.
REQ-011 SHALL have registered outputs ex_valid 1, ex_ctrl ctrl_t, ex_rs_val 32, ex_rt_val 32, ex_imm 32, ex_rs/ex_rt/ex_wreg 5, ex_pc4 32.

Function
REQ-012 SHALL decode opcodes R-type(0), lw(35), sw(43), beq(4), addi(8), j(2) into ctrl_t; any other opcode SHALL decode as all-zero ctrl (NOP).
REQ-013 SHALL set ex_wreg = rd for R-type, rt for lw/addi, 0 otherwise; ex_imm = sign-extended instr[15:0].
REQ-014 SHALL select operand per source: mem stage if mem_wen and mem_wreg==src and src!=0; else wb stage under the same rule; else rf_rdata; mem has priority over wb.
REQ-015 SHALL never forward or stall on register 0.
REQ-016 SHALL detect load-use: registered ex_valid & ex_ctrl.memread & ex_wreg!=0 & ex_wreg matches a source actually used by the ID instruction (rs for all but j; rt for R-type, sw, beq).
REQ-017 On load-use hazard: id_stall=1 for exactly one cycle; next edge loads a bubble (ex_valid=0, ex_ctrl=0); IF/ID content retained and reissued.
REQ-018 Edge priority: ex_flush > ex_hold > hazard > normal load; latency ID->EX exactly one cycle.
REQ-019 ex_flush SHALL load a bubble and force id_stall=0 in the same cycle, regardless of hazard or hold.
REQ-020 ex_hold (without flush) SHALL keep all ex_* registers unchanged and drive id_stall=1.
REQ-021 if_valid=0 SHALL load a bubble with id_stall=0.

Reset
REQ-022 rst SHALL asynchronously clear every ex_* output to 0 (ex_valid=0); id_stall SHALL be 0 while rst=1.
REQ-023 Deassertion mid-stream SHALL resume with the first valid if_instr sampled at the following rising edge.

Configuration
REQ-024 Macro ID_FORWARD_EN defined: forwarding per REQ-014 and stall only per REQ-016.
REQ-025 Macro undefined: operands always rf_rdata; stall (one bubble per cycle, repeated) while a used source matches a nonzero valid ex_wreg with regwrite or mem_wreg with mem_wen; wb-stage matches never stall.

Structure
REQ-026 Package mips_pkg SHALL hold ctrl_t (regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, jump, aluop[2:0]) and opcode constants.
REQ-027 Opcode decode SHALL be a sub-module id_decoder (pure combinational); hazard, forwarding and ID/EX register live in id_ex_stage.

Verification
REQ-028 add $3,$1,$2 with rf_rdata1=5, rf_rdata2=7, no forwarding -> next edge ex_valid=1, ex_rs_val=5, ex_rt_val=7, ex_wreg=3.
REQ-029 mem_wen=1 mem_wreg=1 mem_wdata=0xAA and wb_wen=1 wb_wreg=1 wb_wdata=0xBB, instr uses $1 -> ex_rs_val=0xAA (forwarding build).
REQ-030 lw $4 in EX followed by add $5,$4,$4 -> id_stall=1 one cycle, one bubble, then add issues with id_stall=0.
REQ-031 Load-use hazard plus ex_flush same cycle -> id_stall=0, bubble loaded; ex_hold=1 for 3 cycles -> ex_* unchanged, id_stall=1 throughout.
REQ-032 Writes targeting $0 from mem/wb with instr using $0 and rf_rdata1=0 -> ex_rs_val=0, no stall; rst pulsed mid-stream -> all ex_* 0 immediately.
